// File: rtl/mc_block_fetch_if.sv
// Bus bundle for mc_block_fetch: block request/configuration, zero-latency reference
// read port, destination write port and status.
interface mc_block_fetch_if;
  logic              start;
  logic [31:0]       ref_start_addr;
  logic [31:0]       dst_start_addr;
  logic [31:0]       mb_x_pos;
  logic [31:0]       mb_y_pos;
  logic signed [5:0] mv_x;
  logic signed [5:0] mv_y;
  logic [31:0]       mem_addr;
  logic [7:0]        mem_rdata;
  logic [31:0]       wr_addr;
  logic [7:0]        wr_data;
  logic              wr_en;
  logic              busy;
  logic              done;
  logic [15:0]       pix_sum;

  modport slave (
    input  start, ref_start_addr, dst_start_addr, mb_x_pos, mb_y_pos, mv_x, mv_y,
    input  mem_rdata,
    output mem_addr, wr_addr, wr_data, wr_en, busy, done, pix_sum
  );

  modport master (
    output start, ref_start_addr, dst_start_addr, mb_x_pos, mb_y_pos, mv_x, mv_y,
    output mem_rdata,
    input  mem_addr, wr_addr, wr_data, wr_en, busy, done, pix_sum
  );
endinterface

// File: rtl/mc_block_fetch.sv
// Motion-compensated 16x16 block fetch: reads the MV-displaced reference block and writes it
// to the destination frame in raster order. Optional MC_EDGE_CLAMP_EN enables edge replication.
module mc_block_fetch #(
  parameter int FRAME_WIDTH  = 352,
  parameter int FRAME_HEIGHT = 240,
  parameter int MB_SIZE      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  mc_block_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic signed [33:0] FW_S = 34'(FRAME_WIDTH);
  localparam logic signed [33:0] FH_S = 34'(FRAME_HEIGHT);
  localparam logic signed [33:0] MB_S = 34'(MB_SIZE);
  localparam logic [31:0]        FW_U = 32'(FRAME_WIDTH);
  localparam logic [31:0]        MB_U = 32'(MB_SIZE);
  localparam logic [3:0]         LAST = 4'(MB_SIZE - 1);

  state_t            state_q, state_d;
  logic [31:0]       ref_q, dst_q, mbx_q, mby_q;
  logic signed [5:0] mvx_q, mvy_q;
  logic [3:0]        r_q, c_q;
  logic              accept, fetch_en, last_px;
  logic signed [33:0] rx, ry;
  logic [31:0]       fetch_addr, dst_addr;
  logic [7:0]        pix;
  logic [31:0]       wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              wr_en_q;
  logic [15:0]       pix_sum_q;
`ifdef MC_EDGE_CLAMP_EN
  logic signed [33:0] rx_a, ry_a;
`else
  logic              oob;
`endif

  assign last_px = (r_q == LAST) && (c_q == LAST);

  // Reference coordinates in signed 34-bit so negative MVs at the frame edge stay exact.
  always_comb begin
    rx = $signed({2'b00, mbx_q}) * MB_S + $signed({30'd0, c_q}) + $signed({{28{mvx_q[5]}}, mvx_q});
    ry = $signed({2'b00, mby_q}) * MB_S + $signed({30'd0, r_q}) + $signed({{28{mvy_q[5]}}, mvy_q});
`ifdef MC_EDGE_CLAMP_EN
    rx_a = (rx < 0) ? '0 : ((rx >= FW_S) ? FW_S - 34'sd1 : rx);
    ry_a = (ry < 0) ? '0 : ((ry >= FH_S) ? FH_S - 34'sd1 : ry);
    fetch_addr = 32'($signed({2'b00, ref_q}) + ry_a * FW_S + rx_a);
    pix        = bus.mem_rdata;
`else
    oob        = (rx < 0) || (rx >= FW_S) || (ry < 0) || (ry >= FH_S);
    fetch_addr = oob ? ref_q : 32'($signed({2'b00, ref_q}) + ry * FW_S + rx);
    pix        = oob ? '0 : bus.mem_rdata;
`endif
  end

  assign dst_addr = dst_q + (mby_q * MB_U + {28'd0, r_q}) * FW_U + mbx_q * MB_U + {28'd0, c_q};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    fetch_en     = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.mem_addr = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        bus.busy     = 1'b1;
        fetch_en     = 1'b1;
        bus.mem_addr = fetch_addr;
        if (last_px) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Counters are parked on the last pixel, so the address is unchanged here.
        bus.busy     = 1'b1;
        bus.mem_addr = fetch_addr;
        state_d      = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_q     <= '0;
      dst_q     <= '0;
      mbx_q     <= '0;
      mby_q     <= '0;
      mvx_q     <= '0;
      mvy_q     <= '0;
      r_q       <= '0;
      c_q       <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      pix_sum_q <= '0;
    end else begin
      wr_en_q <= fetch_en;
      if (accept) begin
        ref_q     <= bus.ref_start_addr;
        dst_q     <= bus.dst_start_addr;
        mbx_q     <= bus.mb_x_pos;
        mby_q     <= bus.mb_y_pos;
        mvx_q     <= bus.mv_x;
        mvy_q     <= bus.mv_y;
        r_q       <= '0;
        c_q       <= '0;
        pix_sum_q <= '0;
      end
      if (fetch_en) begin
        wr_data_q <= pix;
        wr_addr_q <= dst_addr;
        pix_sum_q <= pix_sum_q + {8'd0, pix};
        if (!last_px) begin
          c_q <= c_q + 4'd1;
          if (c_q == LAST) r_q <= r_q + 4'd1;
        end
      end
    end
  end

  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.pix_sum = pix_sum_q;

endmodule

// File: tb/tb_mc_block_fetch.sv
// Directed bench for mc_block_fetch: ramp/constant reference frames, frame-edge MVs,
// start re-pulses and mid-block reset.
module tb_mc_block_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_block_fetch_if bus();

  mc_block_fetch #(.FRAME_WIDTH(352), .FRAME_HEIGHT(240), .MB_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int mode = 0;
  logic [31:0] ref_base = '0;

  logic [31:0] ma_log [0:599];
  logic        bz_log [0:599];
  logic        wn_log [0:599];
  logic [15:0] ps_log [0:599];
  logic [31:0] wa_q [0:599];
  logic [7:0]  wd_q [0:599];
  int          wc_q [0:599];
  int          wcount, ndone;
  int          done_cyc [0:3];

  // Reference frame: 8'hAA outside the frame so stray reads are visible.
  function automatic logic [7:0] ref_pix(logic [31:0] a, int md, logic [31:0] base);
    logic [31:0] off;
    off = a - base;
    if (off >= 32'd84480) return 8'hAA;
    if (md == 0) return 8'd100;
    return 8'((off % 352) + (off / 352));
  endfunction

  assign bus.mem_rdata = ref_pix(bus.mem_addr, mode, ref_base);

  function automatic int exp_pix(int md, int mbx, int mby, int mvx, int mvy, int r, int c);
    int x, y;
    x = mbx * 16 + c + mvx;
    y = mby * 16 + r + mvy;
`ifdef MC_EDGE_CLAMP_EN
    if (x < 0) x = 0;
    if (x > 351) x = 351;
    if (y < 0) y = 0;
    if (y > 239) y = 239;
`else
    if (x < 0 || x > 351 || y < 0 || y > 239) return 0;
`endif
    if (md == 0) return 100;
    return (x + y) & 255;
  endfunction

  function automatic logic [31:0] exp_wa(int dst, int mbx, int mby, int r, int c);
    return 32'(dst + (mby * 16 + r) * 352 + mbx * 16 + c);
  endfunction

  task automatic setup(input int mbx, input int mby, input int mvx, input int mvy,
                       input int refa, input int dsta, input int md);
    bus.mb_x_pos       = 32'(mbx);
    bus.mb_y_pos       = 32'(mby);
    bus.mv_x           = 6'(mvx);
    bus.mv_y           = 6'(mvy);
    bus.ref_start_addr = 32'(refa);
    bus.dst_start_addr = 32'(dsta);
    ref_base           = 32'(refa);
    mode               = md;
  endtask

  // start is sampled at edge 0; loop iteration cyc samples in cycle cyc (between edges cyc-1 and cyc).
  task automatic run(input int ncyc, input int p1, input int p2, input int p3, input int rc);
    wcount = 0;
    ndone  = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int cyc = 1; cyc < ncyc && cyc < 600; cyc++) begin
      @(negedge clk);
      ma_log[cyc] = bus.mem_addr;
      bz_log[cyc] = bus.busy;
      wn_log[cyc] = bus.wr_en;
      ps_log[cyc] = bus.pix_sum;
      if (bus.wr_en) begin
        if (wcount < 600) begin
          wa_q[wcount] = bus.wr_addr;
          wd_q[wcount] = bus.wr_data;
          wc_q[wcount] = cyc;
        end
        wcount++;
      end
      if (bus.done) begin
        if (ndone < 4) done_cyc[ndone] = cyc;
        ndone++;
      end
      bus.start = (cyc == p1) || (cyc == p2) || (cyc == p3);
      if (rc != 0) rst_n = (cyc != rc);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    setup(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if ({bus.wr_en, bus.busy, bus.done} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b want 000", {bus.wr_en, bus.busy, bus.done}); end
    n_vec++; if (bus.mem_addr !== 32'd0) begin n_err++; $display("FAIL rst_mem_addr got %0d want 0", bus.mem_addr); end
    n_vec++; if (bus.pix_sum !== 16'd0) begin n_err++; $display("FAIL rst_pix_sum got %0d want 0", bus.pix_sum); end
    n_vec++; if ({bus.wr_addr, bus.wr_data} !== 40'd0) begin n_err++; $display("FAIL rst_wr got %h want 0", {bus.wr_addr, bus.wr_data}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_const_block;
    int errs, berr;
    setup(10, 10, 0, 0, 0, 84480, 0);
    run(262, 0, 0, 0, 0);
    errs = 0;
    berr = 0;
    for (int i = 0; i < 256; i++)
      if (wd_q[i] !== 8'd100 || wa_q[i] !== exp_wa(84480, 10, 10, i / 16, i % 16)) errs++;
    for (int cyc = 1; cyc < 262; cyc++)
      if (bz_log[cyc] !== (cyc <= 257)) berr++;
    n_vec++; if (wcount !== 256) begin n_err++; $display("FAIL const_wcount got %0d want 256", wcount); end
    n_vec++; if (wa_q[0] !== 32'd140960) begin n_err++; $display("FAIL const_first_wr_addr got %0d want 140960", wa_q[0]); end
    n_vec++; if (errs !== 0) begin n_err++; $display("FAIL const_block got %0d bad pixels want 0", errs); end
    n_vec++; if (bus.pix_sum !== 16'd25600) begin n_err++; $display("FAIL const_pix_sum got %0d want 25600", bus.pix_sum); end
    n_vec++; if (done_cyc[0] !== 258 || ndone !== 1) begin n_err++; $display("FAIL const_done got cyc %0d n %0d want cyc 258 n 1", done_cyc[0], ndone); end
    n_vec++; if (wc_q[0] !== 2 || wc_q[255] !== 257) begin n_err++; $display("FAIL const_wr_window got %0d..%0d want 2..257", wc_q[0], wc_q[255]); end
    n_vec++; if (berr !== 0) begin n_err++; $display("FAIL const_busy got %0d bad cycles want 0", berr); end
    n_vec++; if (ma_log[1] !== 32'd56480) begin n_err++; $display("FAIL const_first_mem_addr got %0d want 56480", ma_log[1]); end
    n_vec++; if (ma_log[260] !== 32'd0) begin n_err++; $display("FAIL const_idle_mem_addr got %0d want 0", ma_log[260]); end
  endtask

  task automatic test_ramp_block;
    int errs;
    setup(2, 2, 5, 3, 0, 1000, 1);
    run(262, 0, 0, 0, 0);
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (32'(wd_q[i]) !== 32'(exp_pix(1, 2, 2, 5, 3, i / 16, i % 16)) || wa_q[i] !== exp_wa(1000, 2, 2, i / 16, i % 16)) errs++;
    n_vec++; if (ma_log[1] !== 32'd12357) begin n_err++; $display("FAIL ramp_first_mem_addr got %0d want 12357", ma_log[1]); end
    n_vec++; if (wd_q[0] !== 8'd72) begin n_err++; $display("FAIL ramp_first_data got %0d want 72", wd_q[0]); end
    n_vec++; if (wd_q[255] !== 8'd102) begin n_err++; $display("FAIL ramp_last_data got %0d want 102", wd_q[255]); end
    n_vec++; if (bus.pix_sum !== 16'd22272) begin n_err++; $display("FAIL ramp_pix_sum got %0d want 22272", bus.pix_sum); end
    n_vec++; if (ma_log[256] !== 32'd17652 || ma_log[257] !== 32'd17652) begin n_err++; $display("FAIL ramp_drain_addr got %0d/%0d want 17652", ma_log[256], ma_log[257]); end
    n_vec++; if (errs !== 0) begin n_err++; $display("FAIL ramp_block got %0d bad pixels want 0", errs); end
  endtask

  task automatic test_neg_edge;
    int errs;
    logic [15:0] want_sum;
`ifdef MC_EDGE_CLAMP_EN
    want_sum = 16'd2512;
`else
    want_sum = 16'd2016;
`endif
    setup(0, 0, -4, -2, 0, 0, 1);
    run(262, 0, 0, 0, 0);
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (32'(wd_q[i]) !== 32'(exp_pix(1, 0, 0, -4, -2, i / 16, i % 16))) errs++;
    n_vec++; if (wd_q[0] !== 8'd0) begin n_err++; $display("FAIL neg_first_data got %0d want 0", wd_q[0]); end
    n_vec++; if (wd_q[36] !== 8'd0) begin n_err++; $display("FAIL neg_r2c4 got %0d want 0", wd_q[36]); end
    n_vec++; if (wd_q[53] !== 8'd2) begin n_err++; $display("FAIL neg_r3c5 got %0d want 2", wd_q[53]); end
    n_vec++; if (ma_log[1] !== 32'd0) begin n_err++; $display("FAIL neg_first_mem_addr got %0d want 0", ma_log[1]); end
    n_vec++; if (bus.pix_sum !== want_sum) begin n_err++; $display("FAIL neg_pix_sum got %0d want %0d", bus.pix_sum, want_sum); end
    n_vec++; if (errs !== 0) begin n_err++; $display("FAIL neg_block got %0d bad pixels want 0", errs); end
  endtask

  task automatic test_far_corner;
    int errs, md;
    logic [31:0] want_addr;
    logic [7:0]  want_pix;
    logic [15:0] want_sum;
`ifdef MC_EDGE_CLAMP_EN
    md = 1; want_addr = 32'd89479; want_pix = 8'd78; want_sum = 16'd19968;
`else
    md = 0; want_addr = 32'd5000; want_pix = 8'd0; want_sum = 16'd0;
`endif
    setup(21, 14, 31, 31, 5000, 0, md);
    run(262, 0, 0, 0, 0);
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (wd_q[i] !== want_pix || ma_log[i + 1] !== want_addr) errs++;
    n_vec++; if (ma_log[1] !== want_addr) begin n_err++; $display("FAIL corner_mem_addr got %0d want %0d", ma_log[1], want_addr); end
    n_vec++; if (errs !== 0) begin n_err++; $display("FAIL corner_block got %0d bad pixels want 0", errs); end
    n_vec++; if (bus.pix_sum !== want_sum) begin n_err++; $display("FAIL corner_pix_sum got %0d want %0d", bus.pix_sum, want_sum); end
    n_vec++; if (wa_q[255] !== 32'd84479) begin n_err++; $display("FAIL corner_last_wr_addr got %0d want 84479", wa_q[255]); end
  endtask

  task automatic test_back_to_back;
    int first_blk;
    setup(1, 1, 0, 0, 0, 0, 0);
    run(521, 50, 258, 259, 0);
    first_blk = 0;
    for (int i = 0; i < wcount && i < 600; i++)
      if (wc_q[i] <= 259) first_blk++;
    n_vec++; if (first_blk !== 256) begin n_err++; $display("FAIL b2b_first_writes got %0d want 256", first_blk); end
    n_vec++; if (ndone !== 2) begin n_err++; $display("FAIL b2b_ndone got %0d want 2", ndone); end
    n_vec++; if (done_cyc[0] !== 258 || done_cyc[1] !== 517) begin n_err++; $display("FAIL b2b_done_cycles got %0d,%0d want 258,517", done_cyc[0], done_cyc[1]); end
    n_vec++; if (wcount !== 512) begin n_err++; $display("FAIL b2b_total_writes got %0d want 512", wcount); end
    n_vec++; if (wc_q[256] !== 261) begin n_err++; $display("FAIL b2b_second_first_write got %0d want 261", wc_q[256]); end
    n_vec++; if (bus.pix_sum !== 16'd25600) begin n_err++; $display("FAIL b2b_pix_sum got %0d want 25600", bus.pix_sum); end
  endtask

  task automatic test_reset_mid;
    setup(2, 2, 5, 3, 0, 1000, 1);
    run(401, 0, 0, 0, 100);
    n_vec++; if ({wn_log[101], bz_log[101]} !== 2'b00) begin n_err++; $display("FAIL midrst_flags got %b want 00", {wn_log[101], bz_log[101]}); end
    n_vec++; if (ps_log[101] !== 16'd0 || ma_log[101] !== 32'd0) begin n_err++; $display("FAIL midrst_regs got sum %0d addr %0d want 0 0", ps_log[101], ma_log[101]); end
    n_vec++; if (wcount !== 99) begin n_err++; $display("FAIL midrst_writes got %0d want 99", wcount); end
    n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL midrst_done got %0d want 0", ndone); end
    run(262, 0, 0, 0, 0);
    n_vec++; if (bus.pix_sum !== 16'd22272) begin n_err++; $display("FAIL midrst_rerun_sum got %0d want 22272", bus.pix_sum); end
    n_vec++; if (done_cyc[0] !== 258 || ndone !== 1) begin n_err++; $display("FAIL midrst_rerun_done got cyc %0d n %0d want 258 1", done_cyc[0], ndone); end
  endtask

  initial begin
    test_reset();
    test_const_block();
    test_ramp_block();
    test_neg_edge();
    test_far_corner();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mc_block_fetch.md
Name: mc_block_fetch

Overview:
- Motion-compensation predictor; the decoder-side counterpart of hexbs_top.
- Takes a motion vector (mv_x, mv_y) for one 16x16 macroblock and fetches the displaced block from the reference frame.
- Writes the predicted block into a destination frame in raster order.
- Shares the byte-wide, zero-latency frame-memory read convention used by the motion estimator.

Parameters:
- FRAME_WIDTH, 352, luma frame width in pixels
- FRAME_HEIGHT, 240, luma frame height in pixels
- MB_SIZE, 16, macroblock edge in pixels (fixed 16; r/c counters 4 bits)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- ref_start_addr  in  32  byte address of reference frame pixel (0,0)
- dst_start_addr  in  32  byte address of destination frame pixel (0,0)
- mb_x_pos  in  32  macroblock column index
- mb_y_pos  in  32  macroblock row index
- mv_x  in  6  signed motion vector x, range -32..31
- mv_y  in  6  signed motion vector y, range -32..31
- mem_addr  out  32  reference read address
- mem_rdata  in  8  read data, combinationally valid in the same cycle as mem_addr
- wr_addr  out  32  destination write address
- wr_data  out  8  predicted pixel
- wr_en  out  1  write strobe, one pixel per cycle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- pix_sum  out  16  sum of the 256 predicted pixels; held until the next accepted start

Behaviour:
- Reset: while rst_n is low at a clock edge, all outputs go to 0 and the FSM goes to IDLE. Reset mid-operation aborts the block: no further wr_en and no done.
- FSM states: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
- IDLE: when start=1, latch all address, position and MV inputs; clear pix_sum and the r/c counters; go to FETCH. Later input changes are ignored until the next accepted start.
- Start while busy (in FETCH, DRAIN or DONE) is ignored.
- FETCH: 256 cycles, r outer loop and c inner loop, both 0..15.
  - Reference coordinates: rx = mb_x*16 + c + mv_x, ry = mb_y*16 + r + mv_y, computed in signed 34-bit arithmetic.
  - mem_addr = ref_start_addr + ry*FRAME_WIDTH + rx.
  - mem_rdata is registered the same cycle into wr_data.
  - wr_addr = dst_start_addr + (mb_y*16 + r)*FRAME_WIDTH + mb_x*16 + c, registered alongside wr_data.
  - wr_en = 1 the following cycle.
  - pix_sum accumulates each written pixel (maximum 65280, no overflow).
  - After c=15, r=15 go to DRAIN.
- DRAIN: emits the final write; mem_addr holds its last value.
- DONE: done=1 for one cycle, busy=0; return to IDLE.
- Timing, with start sampled at edge 0:
  - first mem_addr in cycle 1
  - wr_en high cycles 2..257
  - done in cycle 258
  - the next start is accepted in cycle 259 at the earliest
- busy is high for cycles 1..257.
- mem_addr = 0 in IDLE.
- Out-of-frame reference pixels: a pixel is out of frame when rx<0, rx>=FRAME_WIDTH, ry<0 or ry>=FRAME_HEIGHT. Handling is set by the optional feature.
- The destination MB is always in frame; the caller guarantees mb_x_pos <= 21 and mb_y_pos <= 14.

Optional Feature:
- Macro: MC_EDGE_CLAMP_EN.
- Defined: rx is clamped to [0, FRAME_WIDTH-1] and ry to [0, FRAME_HEIGHT-1] before address generation (edge replication). Every read is in frame.
- Undefined: for out-of-frame pixels, mem_addr = ref_start_addr and wr_data = 0 (mem_rdata ignored). In-frame pixels are unaffected.

Test Plan:
1. Reference frame all 100, mv(0,0), mb(10,10), ref=0, dst=84480 -> 256 writes of 100.
   - first wr_addr = 84480 + 160*352 + 160 = 140960
   - pix_sum = 25600
   - done exactly 258 cycles after start
2. Ref pixel = (x+y)&0xFF, mv(5,3), mb(2,2) -> first mem_addr = 35*352 + 37 = 12357.
   - first wr_data = 72; last wr_data = 102
   - pix_sum = 256*87 = 22272
3. Same ramp, mb(0,0), mv(-4,-2):
   - Clamp defined: first wr_data = ref[0] = 0; pixel (r=2, c=4) = 0; pixel (r=3, c=5) = 2.
   - Clamp undefined: the first 2 rows and the first 4 columns of every row write 0.
4. mb(21,14), mv(31,31), clamp defined -> all reads land on ref pixel (351,239); every wr_data = ramp value 78.
5. start re-pulsed at cycles 50 and 258 -> both ignored, exactly 256 wr_en. start at cycle 259 -> accepted, second done at cycle 517.
6. rst_n low at cycle 100 of FETCH -> next cycle wr_en=0, busy=0, pix_sum=0, mem_addr=0; no done for 300 cycles. A subsequent start completes normally.
